// File: rtl/station_sequencer.sv
// -----------------------------------------------------------------------------
// station_sequencer
//
// Rover material-handling sequencer. An IR trigger (synchronised and
// debounced) announces a station pillar; after a detect delay the XADC sample
// is classified COLD / AMBIENT / HOT and compared with the programmed station
// sequence. A match lowers the electromagnet and strobes the "correct station"
// display; either way the sequencer settles, re-arms the IR detector and waits
// for the next pillar to pick up a washer. A missing XADC ready is a sticky
// fault that only RST clears.
//
// Optional build macro:
//   STATION_TEMP_AVG_EN - classify the average of 4 consecutive ready-qualified
//                         samples instead of a single sample.
//
// Ports:
//   CLK            in   system clock (ACLK)
//   RST            in   asynchronous active-high reset
//   trigger        in   IR station detect (1 = pillar), asynchronous to CLK
//   digitalTemp    in   XADC conversion value, TEMP_W bits
//   ready          in   XADC data valid
//   enableIR       out  IR detector power
//   correctStation out  7-segment "correct station" level
//   controlEM      out  electromagnet, 1 = ON
//   controlServo   out  servo, 0 = UP, 1 = DOWN
//   stationIdx     out  index of the expected station
//   wrongStation   out  1-cycle pulse on a class mismatch
//   seqDone        out  1-cycle pulse when the station index wraps
//   fault          out  sticky ready-timeout flag
// -----------------------------------------------------------------------------
module station_sequencer #(
  parameter int                        NUM_STATIONS = 4,
  parameter logic [2*NUM_STATIONS-1:0] SEQ          = 8'b00_10_01_00,
  parameter int                        TEMP_W       = 12,
  parameter int                        COLD_TH      = 1200,
  parameter int                        HOT_TH       = 1900,
  parameter int                        DEB_CYC      = 8,
  parameter int                        DETECT_DLY   = 100,
  parameter int                        SETTLE_DLY   = 500,
  parameter int                        IR_REARM     = 200,
  parameter int                        READY_TO     = 1000
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            trigger,
  input  logic [TEMP_W-1:0]               digitalTemp,
  input  logic                            ready,
  output logic                            enableIR,
  output logic                            correctStation,
  output logic                            controlEM,
  output logic                            controlServo,
  output logic [$clog2(NUM_STATIONS)-1:0] stationIdx,
  output logic                            wrongStation,
  output logic                            seqDone,
  output logic                            fault
);

  localparam int MAX_DLY = (DETECT_DLY > SETTLE_DLY)
                         ? ((DETECT_DLY > READY_TO) ? DETECT_DLY : READY_TO)
                         : ((SETTLE_DLY > READY_TO) ? SETTLE_DLY : READY_TO);
  localparam int CNT_W = $clog2(MAX_DLY) + 1;
  localparam int IDX_W = $clog2(NUM_STATIONS);
  localparam int DEB_W = $clog2(DEB_CYC) + 1;

  localparam logic [1:0] CLS_AMB  = 2'b00;
  localparam logic [1:0] CLS_HOT  = 2'b01;
  localparam logic [1:0] CLS_COLD = 2'b10;
  localparam logic [1:0] CLS_ANY  = 2'b11;

  localparam logic SERVO_UP = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SAMPLE, S_CORRECT, S_SETTLE, S_FINDPICKUP, S_PICKUP, S_FAULT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         sync_ff;
  logic [DEB_W-1:0]   deb_cnt;
  logic               trig_q;

  logic [TEMP_W-1:0]  sample_val;
  logic               sample_done;
  logic [1:0]         sample_cls;
  logic [1:0]         exp_cls;
  logic               sample_match;

  // ---------------------------------------------------------------------------
  // Trigger: 2-flop synchroniser, then a level is accepted only after the
  // synchronised input has differed from trig_q for DEB_CYC consecutive cycles.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking (<=) so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_ff <= '0;
      deb_cnt <= '0;
      trig_q  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], trigger};
      if (sync_ff[1] == trig_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
        trig_q  <= sync_ff[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

`ifdef STATION_TEMP_AVG_EN
  // Four-sample accumulator; cleared while arming so every visit starts fresh.
  logic [TEMP_W+1:0] avg_sum;
  logic [TEMP_W+1:0] sum_next;
  logic [1:0]        avg_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      avg_sum <= '0;
      avg_n   <= '0;
    end else if (state == S_ARM) begin
      avg_sum <= '0;
      avg_n   <= '0;
    end else if (state == S_SAMPLE && ready) begin
      if (avg_n == 2'd3) begin
        avg_sum <= '0;
        avg_n   <= '0;
      end else begin
        avg_sum <= sum_next;
        avg_n   <= avg_n + 2'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Classification and sequence lookup.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sample_val  = digitalTemp;
    sample_done = ready;
`ifdef STATION_TEMP_AVG_EN
    sum_next    = avg_sum + (TEMP_W+2)'(digitalTemp);
    sample_val  = sum_next[TEMP_W+1:2];
    sample_done = ready && (avg_n == 2'd3);
`endif
    if (sample_val <= TEMP_W'(COLD_TH))
      sample_cls = CLS_COLD;
    else if (sample_val >= TEMP_W'(HOT_TH))
      sample_cls = CLS_HOT;
    else
      sample_cls = CLS_AMB;
    exp_cls      = SEQ[{stationIdx, 1'b0} +: 2];
    sample_match = (exp_cls == CLS_ANY) || (exp_cls == sample_cls);
  end

  // ---------------------------------------------------------------------------
  // Main sequencer. All outputs are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= S_IDLE;
      cnt            <= '0;
      enableIR       <= 1'b1;
      correctStation <= 1'b0;
      controlEM      <= 1'b0;
      controlServo   <= SERVO_UP;
      stationIdx     <= '0;
      wrongStation   <= 1'b0;
      seqDone        <= 1'b0;
      fault          <= 1'b0;
    end else begin
      wrongStation <= 1'b0;
      seqDone      <= 1'b0;
      case (state)
        S_IDLE: begin
          controlServo   <= SERVO_UP;
          correctStation <= 1'b0;
          enableIR       <= 1'b1;
          if (trig_q) begin
            enableIR <= 1'b0;
            cnt      <= CNT_W'(DETECT_DLY);
            state    <= S_ARM;
          end
        end
        S_ARM: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(READY_TO);
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          // A sample arriving on the last timeout cycle still wins.
          if (sample_done) begin
            if (sample_match) begin
              state <= S_CORRECT;
            end else begin
              wrongStation <= 1'b1;
              cnt          <= CNT_W'(SETTLE_DLY);
              enableIR     <= (IR_REARM == 0);
              state        <= S_SETTLE;
            end
`ifdef STATION_TEMP_AVG_EN
          end else if (ready) begin
            cnt <= CNT_W'(READY_TO);
`endif
          end else if (cnt == '0) begin
            fault        <= 1'b1;
            enableIR     <= 1'b1;
            controlEM    <= 1'b0;
            controlServo <= SERVO_UP;
            state        <= S_FAULT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_CORRECT: begin
          controlEM      <= 1'b0;
          correctStation <= 1'b1;
          cnt            <= CNT_W'(SETTLE_DLY);
          enableIR       <= (IR_REARM == 0);
          if (stationIdx == IDX_W'(NUM_STATIONS - 1)) begin
            stationIdx <= '0;
            seqDone    <= 1'b1;
          end else begin
            stationIdx <= stationIdx + IDX_W'(1);
          end
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          // Compare against the pre-decrement value so enableIR rises on the
          // same edge the counter reaches SETTLE_DLY-IR_REARM, i.e. exactly
          // IR_REARM cycles after entering SETTLE.
          if (cnt == CNT_W'(SETTLE_DLY - IR_REARM + 1))
            enableIR <= 1'b1;
          if (cnt == '0)
            state <= S_FINDPICKUP;
          else
            cnt <= cnt - CNT_W'(1);
        end
        S_FINDPICKUP: begin
          if (trig_q)
            state <= S_PICKUP;
        end
        S_PICKUP: begin
          controlEM    <= 1'b1;
          controlServo <= correctStation;
          if (!trig_q)
            state <= S_IDLE;
        end
        S_FAULT: begin
          fault        <= 1'b1;
          enableIR     <= 1'b1;
          controlEM    <= 1'b0;
          controlServo <= SERVO_UP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_station_sequencer.sv
// -----------------------------------------------------------------------------
// tb_station_sequencer
//
// Directed bench for station_sequencer with default parameters
// (SEQ: idx0 AMB, idx1 HOT, idx2 COLD, idx3 AMB). Inputs are driven and
// outputs sampled on the falling clock edge. Cycle numbers below count rising
// edges after the one that drops enableIR (ARM entry = edge A):
//   SAMPLE entry A+101, decision A+102, CORRECT->SETTLE A+103,
//   enableIR re-arm 200 edges after SETTLE entry, fault at A+1102.
// With STATION_TEMP_AVG_EN the decision moves 3 edges later (4 samples).
// -----------------------------------------------------------------------------
module tb_station_sequencer;

  localparam int DEB_CYC = 8;
`ifdef STATION_TEMP_AVG_EN
  localparam int X = 3;
`else
  localparam int X = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        trigger;
  logic [11:0] digitalTemp;
  logic        ready;
  logic        enableIR, correctStation, controlEM, controlServo;
  logic [1:0]  stationIdx;
  logic        wrongStation, seqDone, fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  station_sequencer dut (
    .CLK            (CLK),
    .RST            (RST),
    .trigger        (trigger),
    .digitalTemp    (digitalTemp),
    .ready          (ready),
    .enableIR       (enableIR),
    .correctStation (correctStation),
    .controlEM      (controlEM),
    .controlServo   (controlServo),
    .stationIdx     (stationIdx),
    .wrongStation   (wrongStation),
    .seqDone        (seqDone),
    .fault          (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold the trigger until enableIR drops; returns the cycles it took.
  task automatic wait_arm(output int lat);
    trigger = 1'b1;
    lat = 0;
    while (enableIR !== 1'b0 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  // One full station visit. t0 is presented from ARM on; t1..t3 follow on the
  // next three SAMPLE cycles (only the averaging build uses them).
  task automatic visit(input string tag, input logic [11:0] t0, t1, t2, t3,
                       input bit match, input int idx_after, input int done_exp);
    int lat, c_rise, w_rise, ir_rise, w_cnt, d_cnt;
    digitalTemp = t0;
    ready       = 1'b0;
    wait_arm(lat);
    check({tag, " arm_latency"}, lat, DEB_CYC + 3);
    ready  = 1'b1;
    c_rise = 0; w_rise = 0; ir_rise = 0; w_cnt = 0; d_cnt = 0;
    for (int n = 1; n <= 610; n++) begin
      @(negedge CLK);
      if (correctStation === 1'b1 && c_rise == 0) c_rise = n;
      if (wrongStation === 1'b1) begin
        w_cnt++;
        if (w_rise == 0) w_rise = n;
      end
      if (seqDone === 1'b1) d_cnt++;
      if (enableIR === 1'b1 && ir_rise == 0) ir_rise = n;
      case (n)
        102: digitalTemp = t1;
        103: digitalTemp = t2;
        104: digitalTemp = t3;
        105: ready = 1'b0;
        default: ;
      endcase
    end
    check({tag, " correct_rise"}, c_rise, match ? 103 + X : 0);
    check({tag, " wrong_pulses"}, w_cnt, match ? 0 : 1);
    check({tag, " wrong_rise"}, w_rise, match ? 0 : 102 + X);
    check({tag, " seqdone_pulses"}, d_cnt, done_exp);
    check({tag, " ir_rearm"}, ir_rise, (match ? 303 : 302) + X);
    check({tag, " pickup_em"}, controlEM, 1);
    check({tag, " pickup_servo"}, controlServo, match ? 1 : 0);
    check({tag, " idx"}, stationIdx, idx_after);
    trigger = 1'b0;
    repeat (14) @(negedge CLK);
    check({tag, " idle_correct"}, correctStation, 0);
    check({tag, " idle_servo"}, controlServo, 0);
    check({tag, " idle_ir"}, enableIR, 1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, f_rise;
    RST = 1'b1; trigger = 1'b0; ready = 1'b0; digitalTemp = '0;
    repeat (3) @(negedge CLK);
    check("rst enableIR", enableIR, 1);
    check("rst correct", correctStation, 0);
    check("rst em", controlEM, 0);
    check("rst servo", controlServo, 0);
    check("rst idx", stationIdx, 0);
    check("rst wrong", wrongStation, 0);
    check("rst done", seqDone, 0);
    check("rst fault", fault, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Glitch one cycle short of the debounce window: must stay in IDLE.
    trigger = 1'b1;
    repeat (DEB_CYC - 1) @(negedge CLK);
    trigger = 1'b0;
    repeat (20) @(negedge CLK);
    check("glitch enableIR", enableIR, 1);

    // Nominal sequence AMB, HOT, COLD, AMB.
    visit("nom0", 1500, 1500, 1500, 1500, 1, 1, 0);
    visit("nom1", 2000, 2000, 2000, 2000, 1, 2, 0);
    visit("nom2", 1000, 1000, 1000, 1000, 1, 3, 0);
    visit("nom3", 1500, 1500, 1500, 1500, 1, 0, 1);

    // Wrong station at the HOT entry.
    visit("pre_wrong", 1500, 1500, 1500, 1500, 1, 1, 0);
    visit("wrong_hot", 1500, 1500, 1500, 1500, 0, 1, 0);

    // Threshold boundaries.
    visit("hot_1900", 1900, 1900, 1900, 1900, 1, 2, 0);
    visit("cold_1201", 1201, 1201, 1201, 1201, 0, 2, 0);
    visit("cold_1200", 1200, 1200, 1200, 1200, 1, 3, 0);
    visit("amb_1899", 1899, 1899, 1899, 1899, 1, 0, 1);

`ifdef STATION_TEMP_AVG_EN
    visit("pre_avg", 1500, 1500, 1500, 1500, 1, 1, 0);
    visit("avg_hot", 1899, 1900, 1901, 1904, 1, 2, 0);
`else
    // ready arrives on the very cycle the timeout counter reaches zero.
    digitalTemp = 1500;
    ready = 1'b0;
    wait_arm(lat);
    repeat (1101) @(negedge CLK);
    ready = 1'b1;
    @(negedge CLK);
    ready = 1'b0;
    check("rdy_at_zero fault", fault, 0);
    check("rdy_at_zero correct_pre", correctStation, 0);
    @(negedge CLK);
    check("rdy_at_zero correct", correctStation, 1);
    check("rdy_at_zero idx", stationIdx, 1);
    repeat (620) @(negedge CLK);
    trigger = 1'b0;
    repeat (14) @(negedge CLK);
`endif

    // Ready never arrives: fault after READY_TO+1 cycles in SAMPLE.
    ready = 1'b0;
    wait_arm(lat);
    f_rise = 0;
    for (int n = 1; n <= 1200; n++) begin
      @(negedge CLK);
      if (fault === 1'b1 && f_rise == 0) f_rise = n;
    end
    check("timeout fault_rise", f_rise, 1102);
    check("timeout em", controlEM, 0);
    check("timeout servo", controlServo, 0);
    check("timeout enableIR", enableIR, 1);
    trigger = 1'b0;
    repeat (20) @(negedge CLK);
    trigger = 1'b1;
    repeat (50) @(negedge CLK);
    check("fault held", fault, 1);
    check("fault held enableIR", enableIR, 1);

    // Asynchronous reset mid-cycle, observed before the next rising edge.
    #1 RST = 1'b1;
    #1;
    check("async_rst fault", fault, 0);
    check("async_rst idx", stationIdx, 0);
    check("async_rst enableIR", enableIR, 1);
    check("async_rst em", controlEM, 0);
    check("async_rst servo", controlServo, 0);
    check("async_rst correct", correctStation, 0);
    trigger = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    visit("post_rst", 1500, 1500, 1500, 1500, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/station_sequencer.md
Name: station_sequencer

Overview:
- Parametrised successor to the rover's material-handling controller.
- Detects station pillars via the IR trigger and classifies each station's temperature from the XADC as COLD, AMBIENT or HOT.
- Checks the class against a programmable N-entry station sequence, then drives the washer electromagnet, the servo and the 7-segment "correct station" strobe.
- Adds a synchronised and debounced trigger, a ready timeout with a sticky fault, wrong-station and sequence-complete pulses, and an exported station index.

Parameters:
- NUM_STATIONS, 4, sequence length, 2..16.
- SEQ, 8'b00_10_01_00, packed 2-bit class per station; entry i is SEQ[2i+1:2i]. Codes: 00=AMB, 01=HOT, 10=COLD, 11=ANY (always matches).
- TEMP_W, 12, XADC sample width.
- COLD_TH, 1200, sample <= COLD_TH classifies COLD.
- HOT_TH, 1900, sample >= HOT_TH classifies HOT; otherwise AMB. Constraint: HOT_TH > COLD_TH.
- DEB_CYC, 8, cycles the synchronised trigger must hold a new level before it is accepted.
- DETECT_DLY, 100, cycles in ARM before sampling.
- SETTLE_DLY, 500, cycles in SETTLE.
- IR_REARM, 200, elapsed SETTLE cycles before enableIR returns high. Constraint: IR_REARM <= SETTLE_DLY.
- READY_TO, 1000, max cycles to wait for ready in SAMPLE.

Ports:
- CLK  in  1  system clock (ACLK).
- RST  in  1  asynchronous, active-high reset.
- trigger  in  1  IR station detect, 1 = pillar present; asynchronous to CLK.
- digitalTemp  in  TEMP_W  XADC conversion value.
- ready  in  1  XADC data-valid.
- enableIR  out  1  IR detector power.
- correctStation  out  1  7-segment trigger; level.
- controlEM  out  1  electromagnet, 1 = ON.
- controlServo  out  1  0 = UP, 1 = DOWN.
- stationIdx  out  $clog2(NUM_STATIONS)  index of the expected station.
- wrongStation  out  1  1-cycle pulse on mismatch.
- seqDone  out  1  1-cycle pulse when the index wraps.
- fault  out  1  sticky ready-timeout flag.

Behaviour:
- Reset (async, RST=1): state=IDLE, enableIR=1, correctStation=0, controlEM=0, controlServo=UP, stationIdx=0, wrongStation=0, seqDone=0, fault=0. Counters cleared; debounced trigger trig_q=0.
- Trigger path: 2-flop synchroniser, then debounce. trig_q changes only after DEB_CYC consecutive cycles at the new level. Total latency from a trigger edge to trig_q is DEB_CYC+2 cycles.
- One shared down-counter; width is $clog2 of the largest of DETECT_DLY, SETTLE_DLY and READY_TO, plus 1.
- IDLE: controlServo=UP, correctStation=0, enableIR=1. When trig_q=1: enableIR<=0, counter<=DETECT_DLY, go ARM.
- ARM: decrement the counter. At 0, load READY_TO and go SAMPLE. ARM lasts DETECT_DLY+1 cycles.
- SAMPLE: on ready=1, classify digitalTemp and compare with SEQ[stationIdx]. Match goes to CORRECT. Mismatch pulses wrongStation, loads SETTLE_DLY and goes to SETTLE.
- SAMPLE timeout: with ready=0, decrement the counter. At 0 go FAULT.
- SAMPLE boundaries: ready=1 on the same cycle the counter hits 0 counts as a valid sample, not a fault. Sample exactly COLD_TH is COLD; exactly HOT_TH is HOT.
- CORRECT (1 cycle): controlEM<=0, correctStation<=1, load SETTLE_DLY, go SETTLE.
- CORRECT index update: stationIdx<=stationIdx+1; if stationIdx==NUM_STATIONS-1 it wraps to 0 and seqDone pulses.
- SETTLE: decrement the counter. When counter==SETTLE_DLY-IR_REARM, set enableIR<=1. At 0 go FINDPICKUP.
- FINDPICKUP: wait for trig_q=1, then go PICKUP.
- PICKUP: controlEM<=1, controlServo<=correctStation ? DOWN : UP. Stay while trig_q=1; trig_q=0 goes IDLE.
- FAULT: enableIR=1, controlEM=0, controlServo=UP, fault=1. Terminal until RST.
- Trigger activity in ARM, SAMPLE, CORRECT or SETTLE is ignored.
- RST mid-operation returns immediately to reset values, including stationIdx.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro: STATION_TEMP_AVG_EN.
- Defined: SAMPLE accumulates 4 consecutive ready-qualified samples into a TEMP_W+2-bit sum and classifies sum>>2. The READY_TO timeout restarts after each accepted sample.
- Undefined: a single sample is classified, exactly as above.

Test Plan:
- Nominal run, SEQ default: four stations with temps 1500, 2000, 1000, 1500 → correctStation=1 each visit, stationIdx steps 0→1→2→3→0, seqDone pulses once at the 4th, servo DOWN in each PICKUP.
- Wrong station: at idx=1 (HOT expected) present temp 1500 → wrongStation 1-cycle pulse, correctStation=0, servo stays UP in PICKUP, idx remains 1.
- Boundaries: temp 1200 at a COLD entry and 1900 at a HOT entry → both match. Temp 1201 at a COLD entry → mismatch.
- Debounce: trigger glitches high for DEB_CYC-1 cycles → stays IDLE, enableIR=1. Held DEB_CYC cycles → enters ARM, enableIR=0, ARM lasts DETECT_DLY+1 cycles.
- Timeout: ready held 0 in SAMPLE for READY_TO+1 cycles → fault=1, EM=0, servo UP, state held. RST=1 asynchronously → all outputs return to reset values the same cycle.
- IR re-arm: enableIR rises exactly IR_REARM cycles after SETTLE entry. With STATION_TEMP_AVG_EN, samples 1899, 1900, 1901, 1904 (avg 1901) → HOT match.
